cbd_stream: RTL

Parametrised streaming centered-binomial-distribution sampler, generalising the fixed eta=2 noise sampler. It accepts PRF noise as a valid/ready bit stream and emits LANES coefficients per output beat. Output is either signed 16-bit or reduced mod q. It sits between the SHAKE/PRF squeeze output and the NTT/poly buffers, producing r, e1 and e2 for Kyber (eta=2), or eta1=3 noise for Kyber512.

---
 rtl/cbd_stream.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cbd_stream.sv
// Streaming centered-binomial sampler: buffers LSB-first noise bits and emits
// LANES coefficients (a-b over ETA-bit popcounts) per beat, signed or mod Q.
module cbd_stream #(
  parameter int unsigned ETA     = 2,
  parameter int unsigned IN_W    = 64,
  parameter int unsigned LANES   = 4,
  parameter int unsigned COEFF_W = 16,
  parameter int unsigned Q       = 3329
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode_modq,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [LANES*COEFF_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned GRP       = 2 * ETA;
  localparam int unsigned CW        = LANES * GRP;
  localparam int unsigned BUF_W     = IN_W + CW;
  localparam int unsigned IN_BEATS  = 256 * GRP / IN_W;
  localparam int unsigned OUT_BEATS = 256 / LANES;
  localparam int unsigned CNT_W     = $clog2(BUF_W + 1);
  localparam int unsigned IB_W      = $clog2(IN_BEATS + 1);
  localparam int unsigned OB_W      = $clog2(OUT_BEATS + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                     state_q;
  logic [BUF_W-1:0]           buf_q, buf_d, buf_sh;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_mid;
  logic [IB_W-1:0]            ib_q;
  logic [OB_W-1:0]            ob_q;
  logic                       mode_q;
  logic                       out_valid_q, out_last_q, done_q;
  logic [LANES*COEFF_W-1:0]   out_data_q, coef_d;
  logic                       take_in, take_out, out_fire, last_d;

  function automatic logic [COEFF_W-1:0] cbd_coeff(input logic [GRP-1:0] g,
                                                   input logic modq);
    int a;
    int b;
    int c;
    a = 0;
    b = 0;
    for (int unsigned k = 0; k < ETA; k++) begin
      a += int'(g[k]);
      b += int'(g[ETA+k]);
    end
    c = a - b;
    if (modq && c < 0) c = int'(Q) + c;
    return COEFF_W'(c);
  endfunction

  assign in_ready = (state_q == RUN) && (cnt_q <= CNT_W'(BUF_W - IN_W)) &&
                    (ib_q < IB_W'(IN_BEATS));
  assign take_in  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign take_out = (state_q == RUN) && (cnt_q >= CNT_W'(CW)) &&
                    (!out_valid_q || out_ready) && (ob_q < OB_W'(OUT_BEATS));
  assign last_d   = (ob_q == OB_W'(OUT_BEATS - 1));

  // Consume from the bottom first, then append the new beat just above the
  // remaining valid bits; bits above cnt are always zero so OR is safe.
  always_comb begin
    buf_sh  = take_out ? (buf_q >> CW) : buf_q;
    cnt_mid = take_out ? (cnt_q - CNT_W'(CW)) : cnt_q;
    buf_d   = buf_sh;
    cnt_d   = cnt_mid;
    if (take_in) begin
      buf_d = buf_sh | (BUF_W'(in_data) << cnt_mid);
      cnt_d = cnt_mid + CNT_W'(IN_W);
    end
  end

  always_comb begin
    coef_d = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      coef_d[j*COEFF_W +: COEFF_W] = cbd_coeff(buf_q[j*GRP +: GRP], mode_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      ib_q        <= '0;
      ob_q        <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            mode_q      <= mode_modq;
            buf_q       <= '0;
            cnt_q       <= '0;
            ib_q        <= '0;
            ob_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        RUN: begin
          buf_q <= buf_d;
          cnt_q <= cnt_d;
          if (take_in) ib_q <= ib_q + 1'b1;
          if (take_out) begin
            out_data_q  <= coef_d;
            out_valid_q <= 1'b1;
            out_last_q  <= last_d;
            ob_q        <= ob_q + 1'b1;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
          if (out_fire && out_last_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule
